// File: rtl/mrd_sink_framer.sv
// Input framer for a mixed-radix DFT sink. Validates the frame size carried on
// the sop beat, numbers accepted samples within the frame, and reports frame
// completion, early termination and protocol errors as one-cycle pulses.
module mrd_sink_framer #(
  parameter int DW      = 18,
  parameter int MAX_PTS = 1200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic          sink_sop,
  input  logic          sink_eop,
  input  logic [11:0]   sink_dftpts,
  input  logic [DW-1:0] sink_real,
  input  logic [DW-1:0] sink_imag,
  input  logic          busy,
  output logic          fr_sop,
  output logic [11:0]   fr_dftpts,
  output logic          out_valid,
  output logic [11:0]   out_addr,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          fr_done,
  output logic          fr_abort,
  output logic [1:0]    err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SOP  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;

  state_t          state_q;
  logic [11:0]     count_q;
  logic            out_valid_q;
  logic [11:0]     out_addr_q;
  logic [DW-1:0]   out_real_q;
  logic [DW-1:0]   out_imag_q;
  logic            fr_sop_q;
  logic [11:0]     fr_dftpts_q;
  logic            fr_done_q;
  logic            fr_abort_q;
  logic [1:0]      err_q;

  logic            accept;
  logic            size_ok;
  logic            at_last;

  // A size is legal when it is 12 times a 5-smooth number and fits MAX_PTS.
  // The quotient is stripped of its 2, 3 and 5 factors; only 1 may remain.
  function automatic logic size_legal(input logic [11:0] n);
    int unsigned m;
    logic        in_range;
    // NOTE: functions and combinational code use blocking '=' so each line
    // sees the value computed by the line above it.
    in_range = (n >= 12'd12) && (int'(n) <= MAX_PTS) && (n % 12'd12 == 12'd0);
    m = 32'(n) / 32'd12;
    for (int i = 0; i < 9; i++) if (m != 0 && m % 2 == 0) m = m / 2;
    for (int i = 0; i < 6; i++) if (m != 0 && m % 3 == 0) m = m / 3;
    for (int i = 0; i < 4; i++) if (m != 0 && m % 5 == 0) m = m / 5;
    return in_range && (m == 1);
  endfunction

  // Ready is held low in reset; IDLE honours busy, mid-frame states never stall.
  // NOTE: a continuous assign covers every input combination, so no latch can
  // be inferred here.
  assign sink_ready = rst_n && ((state_q != IDLE) || !busy);
  assign accept     = sink_valid && sink_ready;
  assign size_ok    = size_legal(sink_dftpts);
  assign at_last    = (count_q == 12'(fr_dftpts_q - 12'd1));

  // Frame FSM with all outputs registered: one cycle from accepted beat to output.
  // NOTE: sequential state uses non-blocking '<=' so every register samples the
  // pre-edge values; later assignments in this block override the defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      fr_sop_q    <= 1'b0;
      fr_dftpts_q <= '0;
      fr_done_q   <= 1'b0;
      fr_abort_q  <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      out_valid_q <= 1'b0;
      fr_sop_q    <= 1'b0;
      fr_done_q   <= 1'b0;
      fr_abort_q  <= 1'b0;
      err_q       <= ERR_NONE;
      if (accept) begin
        case (state_q)
          IDLE, RECV: begin
            if (sink_sop) begin
              // Start-of-frame handling, shared by IDLE and a RECV restart.
              if (!size_ok) begin
                err_q   <= ERR_SIZE;
                state_q <= sink_eop ? IDLE : DROP;
              end else if (sink_eop) begin
                err_q      <= ERR_LEN;
                fr_abort_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                fr_sop_q    <= 1'b1;
                fr_dftpts_q <= sink_dftpts;
                out_valid_q <= 1'b1;
                out_addr_q  <= '0;
                out_real_q  <= sink_real;
                out_imag_q  <= sink_imag;
                count_q     <= 12'd1;
                state_q     <= RECV;
              end
              // A sop inside a frame kills that frame; the sop error code takes
              // precedence over whatever the new beat would have reported.
              if (state_q == RECV) begin
                err_q      <= ERR_SOP;
                fr_abort_q <= 1'b1;
              end
            end else if (state_q == IDLE) begin
              err_q <= ERR_SOP;
            end else begin
              out_valid_q <= 1'b1;
              out_addr_q  <= count_q;
              out_real_q  <= sink_real;
              out_imag_q  <= sink_imag;
              count_q     <= count_q + 12'd1;
              if (at_last) begin
                if (sink_eop) begin
                  fr_done_q <= 1'b1;
                  state_q   <= IDLE;
                end else begin
                  err_q      <= ERR_LEN;
                  fr_abort_q <= 1'b1;
                  state_q    <= DROP;
                end
              end else if (sink_eop) begin
                err_q      <= ERR_LEN;
                fr_abort_q <= 1'b1;
                state_q    <= IDLE;
              end
            end
          end
          DROP: begin
            if (sink_eop) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fr_sop    = fr_sop_q;
  assign fr_dftpts = fr_dftpts_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign fr_done   = fr_done_q;
  assign fr_abort  = fr_abort_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mrd_sink_framer.sv
// Directed bench for mrd_sink_framer: reset, size legality, full frames,
// busy handshake, illegal sizes, length errors, sop restart, mid-frame reset.
module tb_mrd_sink_framer;

  localparam int DW      = 18;
  localparam int MAX_PTS = 1200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sink_valid = 1'b0;
  logic          sink_ready;
  logic          sink_sop = 1'b0;
  logic          sink_eop = 1'b0;
  logic [11:0]   sink_dftpts = '0;
  logic [DW-1:0] sink_real = '0;
  logic [DW-1:0] sink_imag = '0;
  logic          busy = 1'b0;
  logic          fr_sop;
  logic [11:0]   fr_dftpts;
  logic          out_valid;
  logic [11:0]   out_addr;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic          fr_done;
  logic          fr_abort;
  logic [1:0]    err;

  int   checks = 0;
  int   errors = 0;
  logic ready_seen;

  mrd_sink_framer #(.DW(DW), .MAX_PTS(MAX_PTS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_dftpts(sink_dftpts),
    .sink_real  (sink_real),
    .sink_imag  (sink_imag),
    .busy       (busy),
    .fr_sop     (fr_sop),
    .fr_dftpts  (fr_dftpts),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .fr_done    (fr_done),
    .fr_abort   (fr_abort),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dre(input int i);
    return DW'(i * 7 + 3);
  endfunction

  function automatic logic [DW-1:0] dim(input int i);
    return DW'((i * 13) ^ 32'h155);
  endfunction

  // Present one beat at the falling edge, note ready, then land 1 ns past the
  // rising edge where the registered response to that beat is visible.
  task automatic drive(input logic v, input logic s, input logic e, input int n,
                       input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge clk);
    sink_valid  = v;
    sink_sop    = s;
    sink_eop    = e;
    sink_dftpts = 12'(n);
    sink_real   = re;
    sink_imag   = im;
    #1 ready_seen = sink_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sink_ready, out_valid, out_addr, out_real, out_imag, fr_sop, fr_dftpts,
         fr_done, fr_abort, err} !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b ov=%b addr=%0d re=%0h im=%0h sop=%b n=%0d done=%b abort=%b err=%b required all 0",
               sink_ready, out_valid, out_addr, out_real, out_imag, fr_sop, fr_dftpts, fr_done, fr_abort, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sink_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", sink_ready);
    end
  endtask

  // Single sop+eop beats: legal sizes report a length error, illegal ones a
  // size error; both leave the FSM in IDLE.
  task automatic test_legal_sizes();
    int   ns[10] = '{12, 24, 84, 96, 132, 1200, 1212, 0, 900, 1188};
    bit   lg[10] = '{1, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    logic [4:0] got, exp;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, ns[i], '0, '0);
      got = {out_valid, fr_sop, fr_abort, err};
      exp = lg[i] ? {1'b0, 1'b0, 1'b1, 2'b10} : {1'b0, 1'b0, 1'b0, 2'b11};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL size_rule n=%0d got {ov,sop,abort,err}=%b required %b", ns[i], got, exp);
      end
    end
    // Non-sop beat in IDLE is a protocol error and produces no sample.
    drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
    checks++;
    if ({out_valid, fr_abort, err} !== {1'b0, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL idle_no_sop got ov=%b abort=%b err=%b required 0 0 01", out_valid, fr_abort, err);
    end
    drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  // A complete legal frame; optional idle gaps and busy raised once receiving.
  task automatic test_frame(input int n, input bit gaps, input bit busy_mid);
    logic [17:0] got, exp;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || err !== 2'b00) begin
          errors++;
          $display("FAIL frame_gap i=%0d got ov=%b err=%b required 0 00", i, out_valid, err);
        end
      end
      drive(1'b1, i == 0, i == n - 1, (i == 0) ? n : 0, dre(i), dim(i));
      if (busy_mid && i == 0) busy = 1'b1;
      got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
      exp = {1'b1, 12'(i), i == 0, i == n - 1, 1'b0, 2'b00};
      checks++;
      if (got !== exp || ready_seen !== 1'b1) begin
        errors++;
        $display("FAIL frame_beat n=%0d i=%0d got {ov,addr,sop,done,abort,err}=%h rdy=%b required %h rdy=1",
                 n, i, got, ready_seen, exp);
      end
      checks++;
      if (out_real !== dre(i) || out_imag !== dim(i)) begin
        errors++;
        $display("FAIL frame_data n=%0d i=%0d got %h/%h required %h/%h", n, i, out_real, out_imag, dre(i), dim(i));
      end
      if (i == 0) begin
        checks++;
        if (fr_dftpts !== 12'(n)) begin
          errors++;
          $display("FAIL frame_dftpts got %0d required %0d", fr_dftpts, n);
        end
      end
    end
    busy = 1'b0;
  endtask

  task automatic test_full_frame();
    test_frame(1200, 1'b0, 1'b0);
    // Outputs hold the last sample while nothing is valid.
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
      checks++;
      if ({out_valid, fr_done, out_addr, out_real, out_imag} !== {1'b0, 1'b0, 12'd1199, dre(1199), dim(1199)}) begin
        errors++;
        $display("FAIL hold_last got ov=%b done=%b addr=%0d re=%h im=%h required 0 0 1199 %h %h",
                 out_valid, fr_done, out_addr, out_real, out_imag, dre(1199), dim(1199));
      end
    end
  endtask

  task automatic test_busy();
    busy = 1'b1;
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0, 12, dre(0), dim(0));
      checks++;
      if ({ready_seen, out_valid, fr_sop, err} !== 5'b0) begin
        errors++;
        $display("FAIL busy_stall got rdy=%b ov=%b sop=%b err=%b required 0 0 0 00", ready_seen, out_valid, fr_sop, err);
      end
    end
    busy = 1'b0;
    test_frame(12, 1'b1, 1'b1);
  endtask

  task automatic test_illegal();
    int ns[4] = '{13, 1000, 1236, 84};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, ns[k], '0, '0);
      checks++;
      if ({out_valid, fr_sop, fr_abort, err} !== {1'b0, 1'b0, 1'b0, 2'b11}) begin
        errors++;
        $display("FAIL illegal_size n=%0d got ov=%b sop=%b abort=%b err=%b required 0 0 0 11",
                 ns[k], out_valid, fr_sop, fr_abort, err);
      end
      // In DROP: a sop, a plain beat and the eop beat are all swallowed silently.
      drive(1'b1, 1'b1, 1'b0, 60, '0, '0);
      checks++;
      if ({out_valid, fr_sop, fr_abort, err} !== 5'b0) begin
        errors++;
        $display("FAIL drop_sop n=%0d got ov=%b sop=%b abort=%b err=%b required 0 0 0 00",
                 ns[k], out_valid, fr_sop, fr_abort, err);
      end
      drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
      drive(1'b1, 1'b0, 1'b1, 0, '0, '0);
      checks++;
      if ({out_valid, err} !== 3'b0) begin
        errors++;
        $display("FAIL drop_eop n=%0d got ov=%b err=%b required 0 00", ns[k], out_valid, err);
      end
    end
    test_frame(60, 1'b0, 1'b0);
  endtask

  task automatic test_length();
    logic [17:0] got, exp;
    // Early eop at index 10 of a 24-point frame.
    for (int i = 0; i <= 10; i++) begin
      drive(1'b1, i == 0, i == 10, (i == 0) ? 24 : 0, dre(i), dim(i));
      got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
      exp = (i == 10) ? {1'b1, 12'd10, 1'b0, 1'b0, 1'b1, 2'b10}
                      : {1'b1, 12'(i), i == 0, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL early_eop i=%0d got %h required %h", i, got, exp);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
    checks++;
    if ({out_valid, err} !== {1'b0, 2'b01}) begin
      errors++;
      $display("FAIL early_eop_idle got ov=%b err=%b required 0 01", out_valid, err);
    end
    // Missing eop at index 23 of a 24-point frame.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, i == 0, 1'b0, (i == 0) ? 24 : 0, dre(i), dim(i));
      got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
      exp = (i == 23) ? {1'b1, 12'd23, 1'b0, 1'b0, 1'b1, 2'b10}
                      : {1'b1, 12'(i), i == 0, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL missing_eop i=%0d got %h required %h", i, got, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, i == 2, 0, dre(i), dim(i));
      checks++;
      if ({out_valid, fr_abort, err} !== 4'b0) begin
        errors++;
        $display("FAIL missing_eop_drop k=%0d got ov=%b abort=%b err=%b required 0 0 00", i, out_valid, fr_abort, err);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 0, '0, '0);
    checks++;
    if ({out_valid, err} !== {1'b0, 2'b01}) begin
      errors++;
      $display("FAIL missing_eop_idle got ov=%b err=%b required 0 01", out_valid, err);
    end
    drive(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic test_restart();
    logic [17:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, 1'b0, (i == 0) ? 36 : 0, dre(i), dim(i));
      got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
      exp = {1'b1, 12'(i), i == 0, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_pre i=%0d got %h required %h", i, got, exp);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 48, dre(0), dim(0));
    got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
    exp = {1'b1, 12'd0, 1'b1, 1'b0, 1'b1, 2'b01};
    checks++;
    if (got !== exp || fr_dftpts !== 12'd48) begin
      errors++;
      $display("FAIL restart_sop got %h n=%0d required %h n=48", got, fr_dftpts, exp);
    end
    for (int i = 1; i < 48; i++) begin
      drive(1'b1, 1'b0, i == 47, 0, dre(i), dim(i));
      got = {out_valid, out_addr, fr_sop, fr_done, fr_abort, err};
      exp = {1'b1, 12'(i), 1'b0, i == 47, 1'b0, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_post i=%0d got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= 100; i++) begin
      drive(1'b1, i == 0, 1'b0, (i == 0) ? 600 : 0, dre(i), dim(i));
      checks++;
      if ({out_valid, out_addr, err} !== {1'b1, 12'(i), 2'b00}) begin
        errors++;
        $display("FAIL reset_mid_pre i=%0d got ov=%b addr=%0d err=%b required 1 %0d 00", i, out_valid, out_addr, err, i);
      end
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    rst_n      = 1'b0;
    sink_valid = 1'b0;
    #1;
    checks++;
    if ({sink_ready, out_valid, out_addr, out_real, out_imag, fr_sop, fr_dftpts,
         fr_done, fr_abort, err} !== '0) begin
      errors++;
      $display("FAIL reset_async got rdy=%b ov=%b addr=%0d re=%h im=%h sop=%b n=%0d done=%b abort=%b err=%b required all 0",
               sink_ready, out_valid, out_addr, out_real, out_imag, fr_sop, fr_dftpts, fr_done, fr_abort, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, fr_abort, err} !== 4'b0) begin
        errors++;
        $display("FAIL reset_silent got ov=%b abort=%b err=%b required 0 0 00", out_valid, fr_abort, err);
      end
    end
    test_frame(600, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_legal_sizes();
    test_full_frame();
    test_busy();
    test_illegal();
    test_length();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrd_sink_framer.md
MRD_SINK_FRAMER -- requirements
Module: mrd_sink_framer

Interface
REQ-001 Parameters SHALL be: DW, default 18, I/Q sample width; MAX_PTS, default 1200, largest legal DFT size.
REQ-002 clk  in  1  the block's single clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 sink_valid  in  1  input beat valid.
REQ-005 sink_ready  out  1  block accepts a beat this cycle; a beat transfers when sink_valid&sink_ready.
REQ-006 sink_sop, sink_eop  in  1 each  first and last beat of a frame.
REQ-007 sink_dftpts  in  12  frame size; sampled only on an accepted sop beat.
REQ-008 sink_real, sink_imag  in  DW each  input sample.
REQ-009 busy  in  1  downstream memory cannot start a new frame.
REQ-010 fr_sop  out  1  one-cycle frame-start pulse to the control FSM.
REQ-011 fr_dftpts  out  12  latched frame size; held until the next fr_sop.
REQ-012 out_valid  out  1; out_addr  out  12; out_real, out_imag  out  DW each  registered sample and its index within the frame.
REQ-013 fr_done, fr_abort  out  1 each  one-cycle pulses: frame completed, or frame terminated early.
REQ-014 err  out  2  one-cycle error code: 00 none, 01 sop protocol error, 10 length mismatch, 11 illegal dftpts.

Function
REQ-015 Legal size rule: 12 <= N <= MAX_PTS, N%12==0, and N/12 has no prime factor other than 2, 3 or 5. Implement as a combinational check or a constant table.
REQ-016 FSM states SHALL be IDLE, RECV and DROP.
REQ-017 sink_ready in IDLE SHALL be !busy; in RECV and DROP it SHALL be 1.
REQ-018 IDLE, accepted sop beat with legal N and sink_eop=0:
  - fr_sop=1, fr_dftpts=N, out_valid=1, out_addr=0 on the next cycle;
  - internal count := 1;
  - go to RECV.
REQ-019 IDLE, accepted sop beat with legal N and sink_eop=1: err=10 and fr_abort next cycle, no fr_sop, stay IDLE.
REQ-020 IDLE, accepted sop beat with illegal N: err=11 next cycle, no outputs. Go to DROP, or stay IDLE if that beat carries eop.
REQ-021 IDLE, accepted beat without sop: err=01 next cycle, beat discarded, stay IDLE.
REQ-022 RECV, accepted non-sop beat:
  - next cycle out_valid=1, out_addr=count, data registered;
  - count increments.
REQ-023 RECV completion: when the beat at index fr_dftpts-1 carries eop, fr_done=1 in the same cycle as its out_valid, then go to IDLE.
REQ-024 RECV early eop (index < fr_dftpts-1): the beat is output, then err=10 and fr_abort=1 in the same cycle, go to IDLE.
REQ-025 RECV missing eop at index fr_dftpts-1: the beat is output, then err=10 and fr_abort=1, go to DROP.
REQ-026 RECV, accepted sop beat:
  - err=01 and fr_abort=1 next cycle;
  - the beat is then handled as in IDLE (REQ-018..020) in the same cycle, so a legal sop restarts a frame with fr_sop co-asserted with fr_abort;
  - busy is ignored for this restart.
REQ-027 DROP: accepted beats are discarded with no out_valid. A beat with eop returns the FSM to IDLE; sop beats in DROP do not raise an error.
REQ-028 Latency SHALL be exactly 1 cycle from accepted beat to out_valid, fr_sop, fr_done, fr_abort and err. There is no backpressure on outputs; downstream always accepts out_valid.
REQ-029 out_addr SHALL be 12-bit unsigned and never wraps, because count is bounded by fr_dftpts <= MAX_PTS.
REQ-030 When out_valid=0, out_real, out_imag and out_addr SHALL hold their last values.

Reset
REQ-031 While rst_n=0, these outputs SHALL be 0: FSM state IDLE, count, out_valid, out_addr, out_real, out_imag, fr_sop, fr_dftpts, fr_done, fr_abort, err. sink_ready SHALL be 0 during reset and follow REQ-017 after release.
REQ-032 Reset asserted mid-frame SHALL abandon the frame silently, with no fr_abort or err pulse. After release the block waits in IDLE for a new sop.

Verification
REQ-033 Legal 1200-point frame, busy=0, continuous valid: fr_sop with fr_dftpts=1200, then 1200 out_valid beats with addr 0..1199, fr_done with addr 1199, err never nonzero.
REQ-034 busy=1 in IDLE with a pending 12-point sop: sink_ready=0 and no output. When busy drops, the frame runs with gaps in sink_valid; addr 0..11 contiguous, fr_done at addr 11.
REQ-035 Illegal sizes: sop with N=13, 1000 (not a multiple of 12), 1236 (above MAX_PTS), and 12*7=84: err=11 each time, no fr_sop, beats dropped until eop; a following legal 60-point frame completes normally.
REQ-036 Length errors on a 24-point frame: eop at index 10 gives err=10 and fr_abort with addr 10. No eop at index 23 gives err=10 and fr_abort, then beats drop until eop.
REQ-037 sop at index 5 of a 36-point frame with new N=48: err=01 and fr_abort co-asserted with fr_sop, fr_dftpts=48, and addr restarts at 0.
REQ-038 rst_n pulsed low at index 100 of a 600-point frame: all outputs go 0 asynchronously with no error pulse; a fresh 600-point frame afterwards completes with addr 0..599.
